// File: rtl/freq_meter.sv
// Period and high-time meter for a slow asynchronous input.
// Counts CLOCK cycles between synchronized rising edges of sig_in and flags a timeout when edges stop.
module freq_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cycles,
  output logic             period_valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             s1_d, s2_d, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_cycles_q, high_cycles_d;
  logic             period_valid_q, period_valid_d;
  logic             timeout_q, timeout_d;
  logic             rise_s;

  assign rise_s = s2_q & ~s3_q;

  // Synchronizer chain plus edge-history stage.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Measurement FSM: counters, results, valid strobe and timeout.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hi_d           = hi_q;
    period_d       = period_q;
    high_cycles_d  = high_cycles_q;
    period_valid_d = 1'b0;
    timeout_d      = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d   = MEASURE;
          cnt_d     = ONE_C;
          hi_d      = ONE_C;
          timeout_d = 1'b0;
        end else begin
          cnt_d = ZERO_C;
          hi_d  = ZERO_C;
        end
      end
      MEASURE: begin
        // A rise on the same cycle as cnt == TIMEOUT still counts as a valid measurement.
        if (rise_s) begin
          period_d       = cnt_q;
          high_cycles_d  = hi_q;
          period_valid_d = 1'b1;
          cnt_d          = ONE_C;
          hi_d           = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d       = IDLE;
          timeout_d     = 1'b1;
          period_d      = ZERO_C;
          high_cycles_d = ZERO_C;
          cnt_d         = ZERO_C;
          hi_d          = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
          hi_d  = hi_q + {{(CNT_W-1){1'b0}}, s2_q};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO_C;
        hi_d    = ZERO_C;
      end
    endcase
  end

  // All state updates on the falling edge of CLOCK.
  always_ff @(negedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= ZERO_C;
      hi_q           <= ZERO_C;
      period_q       <= ZERO_C;
      high_cycles_q  <= ZERO_C;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      cnt_q          <= cnt_d;
      hi_q           <= hi_d;
      period_q       <= period_d;
      high_cycles_q  <= high_cycles_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_cycles  = high_cycles_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;

endmodule
